sig_ctrl: RTL

Control front-end that sits directly upstream of the dual-address phase counter in the signal generator. It produces the counter's enable strobe from a programmable prescaler, which sets the output frequency. It also maintains the phase offset word, stepped by a debounced push-button with auto-repeat. Its outputs connect straight to the counter's en and offset inputs.

---
 rtl/sig_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/sig_ctrl.sv
// sig_ctrl: prescaled enable strobe and debounced, auto-repeating phase offset stepper
module sig_ctrl #(
    parameter int WIDTH     = 9,
    parameter int DIV_WIDTH = 16,
    parameter int DEBOUNCE  = 1000,
    parameter int REPEAT    = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn,
    input  logic                 dir,
    input  logic [WIDTH-1:0]     step,
    input  logic [DIV_WIDTH-1:0] rate,
    output logic                 en_out,
    output logic [WIDTH-1:0]     offset_out,
    output logic                 press
);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int RW = REPEAT > 0 ? $clog2(REPEAT + 1) : 1;
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
    state_t               r_state, w_state_nxt;
    logic [DIV_WIDTH-1:0] r_count;
    logic [1:0]           r_sync;
    logic [DW-1:0]        r_deb, w_deb_nxt;
    logic [RW-1:0]        r_rep, w_rep_nxt;
    logic                 w_btn_s, w_apply;
    assign w_btn_s = r_sync[1];
    // prescaler: strobe once every rate+1 cycles, restarting as soon as count reaches rate
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            en_out  <= 1'b0;
        end else if (r_count >= rate) begin
            r_count <= '0;
            en_out  <= 1'b1;
        end else begin
            r_count <= r_count + 1'b1;
            en_out  <= 1'b0;
        end
    end
    // two-flop synchroniser for the asynchronous button
    always_ff @(posedge clk) begin
        r_sync <= rst ? 2'b00 : {r_sync[0], btn};
    end
    // button FSM: debounce both edges, step on acceptance and on each repeat interval
    always_comb begin
        w_state_nxt = r_state;
        w_deb_nxt   = r_deb;
        w_rep_nxt   = r_rep;
        w_apply     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_btn_s) begin
                    w_state_nxt = PRESS_WAIT;
                    w_deb_nxt   = DW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!w_btn_s) w_state_nxt = IDLE;
                else if (r_deb == DW'(DEBOUNCE)) begin
                    w_state_nxt = HELD;
                    w_rep_nxt   = '0;
                    w_apply     = 1'b1;
                end else w_deb_nxt = r_deb + 1'b1;
            end
            HELD: begin
                if (!w_btn_s) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_deb_nxt   = DW'(1);
                end else if (REPEAT != 0) begin
                    if (r_rep == RW'(REPEAT - 1)) begin
                        w_rep_nxt = '0;
                        w_apply   = 1'b1;
                    end else w_rep_nxt = r_rep + 1'b1;
                end
            end
            RELEASE_WAIT: begin
                if (w_btn_s) w_state_nxt = HELD;
                else if (r_deb == DW'(DEBOUNCE)) w_state_nxt = IDLE;
                else w_deb_nxt = r_deb + 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end
    // state, counters and the offset word; dir/step only matter on an apply edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_deb      <= '0;
            r_rep      <= '0;
            offset_out <= '0;
            press      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_deb      <= w_deb_nxt;
            r_rep      <= w_rep_nxt;
            press      <= w_apply;
            if (w_apply) offset_out <= dir ? offset_out - step : offset_out + step;
        end
    end
endmodule
